// File: rtl/adc_xy_fade_pkg.sv
// Shared types and constants for the XY scope framebuffer fade engine.
package adc_xy_fade_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } fade_state_t;

  localparam int unsigned FADE_LINEAR = 0;
  localparam int unsigned FADE_EXP    = 1;

endpackage

// File: rtl/adc_xy_fade_engine_pixel_decay.sv
// Combinational per-channel fade of one packed pixel.
// Linear mode subtracts DECAY and clamps at 0; exponential mode subtracts ch >> DECAY,
// falling back to a decrement of 1 so small non-zero values still reach 0.
module pixel_decay
  import adc_xy_fade_pkg::*;
#(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned FADE_MODE  = FADE_LINEAR,
  parameter int unsigned DECAY      = 1
) (
  input  logic [CHANNELS*COLOR_BITS-1:0] i_pixel,
  output logic [CHANNELS*COLOR_BITS-1:0] o_pixel
);

  logic [COLOR_BITS-1:0] w_ch;
  logic [COLOR_BITS-1:0] w_sh;

  // Fade every channel independently; never wraps below zero.
  always_comb begin
    o_pixel = '0;
    w_ch    = '0;
    w_sh    = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      w_ch = i_pixel[c*COLOR_BITS +: COLOR_BITS];
      w_sh = w_ch >> DECAY;
      if (FADE_MODE == FADE_EXP) begin
        if (w_sh == '0 && w_ch != '0) begin
          o_pixel[c*COLOR_BITS +: COLOR_BITS] = w_ch - COLOR_BITS'(1);
        end else begin
          o_pixel[c*COLOR_BITS +: COLOR_BITS] = w_ch - w_sh;
        end
      end else begin
        if (32'(w_ch) >= DECAY) begin
          o_pixel[c*COLOR_BITS +: COLOR_BITS] = w_ch - COLOR_BITS'(DECAY);
        end else begin
          o_pixel[c*COLOR_BITS +: COLOR_BITS] = '0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_xy_fade_engine.sv
// Framebuffer persistence engine: plots XY points at full intensity and sweeps the whole
// framebuffer on request, fading every pixel. Point writes win arbitration over fade traffic.
module adc_xy_fade_engine
  import adc_xy_fade_pkg::*;
#(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned COORD_BITS = 10,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned ADDR_BITS  = 20,
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned FADE_MODE  = FADE_LINEAR,
  parameter int unsigned DECAY      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [COORD_BITS-1:0] pt_x,
  input  logic [COORD_BITS-1:0] pt_y,
  input  logic [CHANNELS-1:0]   pt_color,
  input  logic                  fade_start,
  output logic                  fade_busy,
  output logic                  fade_done,
  output logic [15:0]           drop_cnt,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_BITS-1:0]  mem_cmd_addr,
  output logic [DATA_BITS-1:0]  mem_cmd_wdata,
  input  logic                  mem_rd_valid,
  input  logic [DATA_BITS-1:0]  mem_rd_data
);

  localparam int unsigned          PIXEL_BITS = CHANNELS * COLOR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(H_RES * V_RES - 1);

  // Point register
  logic                  r_pt_full;
  logic [ADDR_BITS-1:0]  r_pt_addr;
  logic [DATA_BITS-1:0]  r_pt_data;
  logic [15:0]           r_drop_cnt;
  // Arbiter
  logic                  r_lock;
  logic                  r_gnt_pt;
  // Fade FSM
  fade_state_t           r_state, w_state_n;
  logic [ADDR_BITS-1:0]  r_faddr, w_faddr_n;
  logic [PIXEL_BITS-1:0] r_fdata, w_fdata_n;
  logic                  r_cancel, w_cancel_n;
  logic                  r_pend, w_pend_n;
  logic                  r_done, w_done_n;

  logic                  w_pt_acc;
  logic                  w_pt_in_range;
  logic [ADDR_BITS-1:0]  w_pt_addr;
  logic [DATA_BITS-1:0]  w_pt_data;
  logic                  w_gnt_pt;
  logic                  w_fade_req;
  logic                  w_cmd_acc;
  logic                  w_pt_wr_acc;
  logic                  w_fade_acc;
  logic [PIXEL_BITS-1:0] w_faded;
  logic                  w_unused_rd;

  assign w_unused_rd   = ^mem_rd_data;

  assign pt_ready      = reset_n && !r_pt_full;
  assign w_pt_acc      = pt_valid && pt_ready;
  assign w_pt_in_range = (32'(pt_x) < H_RES) && (32'(pt_y) < V_RES);
  assign w_pt_addr     = ADDR_BITS'(32'(pt_y) * H_RES + 32'(pt_x));

  // Expand the per-channel enable into full-intensity channel values.
  always_comb begin
    w_pt_data = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      w_pt_data[c*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{pt_color[c]}};
    end
  end

  // Grant stays with whoever presented a command until it is accepted.
  assign w_gnt_pt      = r_lock ? r_gnt_pt : r_pt_full;
  assign w_fade_req    = (r_state == RD_REQ) || (r_state == WR_REQ && !r_cancel);
  assign mem_cmd_valid = w_gnt_pt ? r_pt_full : w_fade_req;
  assign mem_cmd_we    = w_gnt_pt ? 1'b1 : (r_state == WR_REQ);
  assign mem_cmd_addr  = w_gnt_pt ? r_pt_addr : r_faddr;
  assign mem_cmd_wdata = w_gnt_pt ? r_pt_data : DATA_BITS'(r_fdata);
  assign w_cmd_acc     = mem_cmd_valid && mem_cmd_ready;
  assign w_pt_wr_acc   = w_cmd_acc && w_gnt_pt;
  assign w_fade_acc    = w_cmd_acc && !w_gnt_pt;

  assign fade_busy     = (r_state != IDLE);
  assign fade_done     = r_done;
  assign drop_cnt      = r_drop_cnt;

  pixel_decay #(
    .CHANNELS  (CHANNELS),
    .COLOR_BITS(COLOR_BITS),
    .FADE_MODE (FADE_MODE),
    .DECAY     (DECAY)
  ) u_decay (
    .i_pixel(mem_rd_data[PIXEL_BITS-1:0]),
    .o_pixel(w_faded)
  );

  // Point register and drop counter; out-of-range points are consumed without a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pt_full  <= 1'b0;
      r_pt_addr  <= '0;
      r_pt_data  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pt_wr_acc) r_pt_full <= 1'b0;
      if (w_pt_acc) begin
        if (w_pt_in_range) begin
          r_pt_full <= 1'b1;
          r_pt_addr <= w_pt_addr;
          r_pt_data <= w_pt_data;
        end else if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  // Arbiter lock: remember the grant while a command is stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock   <= 1'b0;
      r_gnt_pt <= 1'b0;
    end else begin
      r_lock   <= mem_cmd_valid && !mem_cmd_ready;
      r_gnt_pt <= w_gnt_pt;
    end
  end

  // Fade FSM next state, pending start and write-cancel hazard tracking.
  always_comb begin
    w_state_n  = r_state;
    w_faddr_n  = r_faddr;
    w_fdata_n  = r_fdata;
    w_cancel_n = r_cancel;
    w_pend_n   = r_pend;
    w_done_n   = 1'b0;
    case (r_state)
      IDLE: begin
        if (fade_start || r_pend) begin
          w_state_n  = RD_REQ;
          w_faddr_n  = '0;
          w_pend_n   = 1'b0;
          w_cancel_n = 1'b0;
        end
      end
      RD_REQ: begin
        if (w_fade_acc) w_state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rd_valid) begin
          w_state_n = WR_REQ;
          w_fdata_n = w_faded;
        end
      end
      WR_REQ: begin
        if (w_fade_acc || r_cancel) begin
          w_cancel_n = 1'b0;
          if (r_faddr == LAST_ADDR) begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = RD_REQ;
            w_faddr_n = r_faddr + ADDR_BITS'(1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
    if (fade_start && r_state != IDLE) w_pend_n = 1'b1;
    // A point landing on the pixel being faded makes the read data stale; skip its write-back.
    if (w_pt_wr_acc && r_pt_addr == r_faddr && (r_state == RD_WAIT || r_state == WR_REQ) &&
        !(r_state == WR_REQ && r_cancel)) begin
      w_cancel_n = 1'b1;
    end
  end

  // Fade FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_faddr  <= '0;
      r_fdata  <= '0;
      r_cancel <= 1'b0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_faddr  <= w_faddr_n;
      r_fdata  <= w_fdata_n;
      r_cancel <= w_cancel_n;
      r_pend   <= w_pend_n;
      r_done   <= w_done_n;
    end
  end

endmodule
